// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter sharing one 8:1 mux; MUX8_ARB_TIMEOUT_EN enables forced release after MAX_HOLD cycles
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] I,
  output logic [7:0] gnt,
  output logic [2:0] S,
  output logic       busy,
  output logic       Y,
  output logic       timeout
);
`ifdef MUX8_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_state;
  logic [2:0] r_ptr, w_ptr, r_s, w_s, w_off, w_win;
  logic [7:0] r_gnt, w_gnt, w_rot;
  logic r_busy, w_busy, r_timeout, w_timeout, w_force;
  logic [HOLD_W-1:0] r_hold, w_hold;
  // rotate requests so bit 0 is the current highest-priority requester
  assign w_rot = 8'({req, req} >> r_ptr);
  // lowest set bit of the rotated vector is the winner's offset from ptr
  always_comb begin
    w_off = '0;
    for (int k = 7; k >= 0; k--)
      if (w_rot[k]) w_off = 3'(k);
  end
  assign w_win = r_ptr + w_off;
  assign w_force = TIMEOUT_EN && req[r_s] && (r_hold == HOLD_W'(MAX_HOLD - 1));
  // next-state: grant from idle, release on drop or forced timeout
  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_s       = r_s;
    w_gnt     = r_gnt;
    w_busy    = r_busy;
    w_hold    = &r_hold ? r_hold : r_hold + HOLD_W'(1);
    w_timeout = 1'b0;
    if (r_state == IDLE) begin
      w_hold = '0;
      if (|req) begin
        w_state = GRANT;
        w_s     = w_win;
        w_gnt   = 8'b1 << w_win;
        w_busy  = 1'b1;
      end
    end else if (!req[r_s] || w_force) begin
      w_state   = IDLE;
      w_ptr     = r_s + 3'd1;
      w_gnt     = '0;
      w_busy    = 1'b0;
      w_timeout = w_force;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_s       <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_s       <= w_s;
      r_gnt     <= w_gnt;
      r_busy    <= w_busy;
      r_hold    <= w_hold;
      r_timeout <= w_timeout;
    end
  end
  assign gnt     = r_gnt;
  assign S       = r_s;
  assign busy    = r_busy;
  assign timeout = r_timeout;
  assign Y       = r_busy & I[r_s];
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: randomized scoreboard bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] req, I, gnt;
  logic [2:0] S;
  logic busy, Y, timeout;
  always #5 clk = ~clk;
  mux8_rr_arbiter dut (.clk(clk), .rst(rst), .req(req), .I(I), .gnt(gnt), .S(S),
                       .busy(busy), .Y(Y), .timeout(timeout));
`ifdef MUX8_ARB_TIMEOUT_EN
  localparam int MH = 16;
`else
  localparam int MH = 0;
`endif
  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic busy;
    logic y;
    logic to;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int checks = 0, passed = 0;
  int m_owner = -1, m_ptr = 0, m_s = 0, m_hold = 0;
  logic m_to = 1'b0;
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] b);
    checks++;
    if (a === b) passed++;
    else $display("FAIL %s got %h want %h at %0t", n, a, b, $time);
  endtask
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    I = d;
    if (r) begin
      m_owner = -1; m_s = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++)
        if (m_owner < 0 && rq[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      if (m_owner >= 0) begin
        m_s = m_owner;
        m_hold = 1;
      end
    end else if (!rq[m_owner] || (MH > 0 && m_hold == MH)) begin
      m_to = rq[m_owner];
      m_ptr = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
      m_hold++;
      m_to = 1'b0;
    end
    e.gnt = m_owner >= 0 ? 8'(1 << m_owner) : 8'h00;
    e.s = 3'(m_s);
    e.busy = m_owner >= 0;
    e.y = e.busy ? d[m_s] : 1'b0;
    e.to = m_to;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk("gnt", gnt, m_e.gnt);
      chk("S", 8'(S), 8'(m_e.s));
      chk("busy", 8'(busy), 8'(m_e.busy));
      chk("Y", 8'(Y), 8'(m_e.y));
      chk("timeout", 8'(timeout), 8'(m_e.to));
    end
  end
  initial begin
    logic [7:0] rq;
    rst = 1'b1;
    req = 8'h00;
    I = 8'h00;
    repeat (2) step(1'b1, 8'hFF, 8'($urandom));
    repeat (4) step(1'b0, 8'hFF, 8'($urandom));
    step(1'b1, 8'h00, 8'h00);
    repeat (3) step(1'b0, 8'h24, 8'($urandom));
    repeat (4) step(1'b0, 8'h20, 8'($urandom));
    step(1'b1, 8'h00, 8'h00);
    for (int c = 0; c < 90; c++) begin
      rq = 8'hFF;
      if (m_owner >= 0 && m_hold >= 3) rq[m_owner] = 1'b0;
      step(1'b0, rq, 8'($urandom));
    end
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'h08, 8'h08);
    step(1'b0, 8'h08, 8'h08);
    step(1'b0, 8'h08, 8'h00);
    step(1'b0, 8'h08, 8'h10);
    step(1'b0, 8'h08, 8'h18);
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'h81, 8'hFF);
    repeat (40) step(1'b0, 8'h81, 8'($urandom));
    step(1'b1, 8'h00, 8'h00);
    repeat (100) step(1'b0, 8'h01, 8'($urandom));
    step(1'b1, 8'h01, 8'hFF);
    repeat (3) step(1'b0, 8'h01, 8'hFF);
    rq = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 7))
        0: rq = 8'($urandom);
        1, 2: rq[$urandom_range(0, 7)] ^= 1'b1;
        3: if (m_owner >= 0) rq[m_owner] = 1'b0;
        default: ;
      endcase
      step($urandom_range(0, 99) == 0, rq, 8'($urandom));
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain got %0d left want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
